// File: rtl/aes_pkg.sv
// Shared widths and types for the AES cipher-text output path.
package aes_pkg;
  localparam int AES_DATA_W        = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = AES_DATA_W / AES_WORD_W;

  typedef logic [AES_DATA_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;
endpackage

// File: rtl/aes_blk_fifo.sv
// Whole-block FIFO: DEPTH entries of DATA_W bits, push/pop with registered count.
// Storage is not reset; only pointers and count are.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W,
  parameter int DEPTH  = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Caller only pushes with a free slot (or a same-cycle pop) and only pops when non-empty.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/aes_ct_serializer.sv
// Buffers AES cipher blocks and streams them MS-word first over valid/ready.
// Optional AES_CT_PARITY_EN adds word_par, the XOR reduction of word_data.
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W,
  parameter int WORD_W = AES_WORD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_valid,
  input  logic [DATA_W-1:0] blk_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  output logic              full,
  output logic              overflow
`ifdef AES_CT_PARITY_EN
  ,
  output logic              word_par
`endif
);

  localparam int N   = DATA_W / WORD_W;
  localparam int WIW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  logic [WIW-1:0]    widx_q, widx_d;
  logic              overflow_q, overflow_d;
  logic              at_last, xfer, pop, push;
  logic [WORD_W-1:0] word_sel;

  aes_blk_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (blk_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // A full FIFO still accepts a block when the head's last word leaves in the same cycle.
  always_comb begin
    word_valid = (count != '0);
    at_last    = (widx_q == WIW'(N - 1));
    xfer       = word_valid && word_ready;
    pop        = xfer && at_last;
    push       = blk_valid && ((count != CW'(DEPTH)) || pop);
    widx_d     = widx_q;
    if (xfer) widx_d = at_last ? '0 : widx_q + WIW'(1);
    overflow_d = overflow_q | (blk_valid & ~push);
    word_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (widx_q == WIW'(i)) word_sel = head[(N-1-i)*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      widx_q     <= widx_d;
      overflow_q <= overflow_d;
    end
  end

  // Gating on word_valid keeps the output at zero while the unreset storage is stale.
  assign word_data = word_valid ? word_sel : '0;
  assign word_last = word_valid && at_last;
  assign full      = (count == CW'(DEPTH));
  assign overflow  = overflow_q;

`ifdef AES_CT_PARITY_EN
  assign word_par = ^word_data;
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Self-checking bench for aes_ct_serializer: queue-of-words reference model plus directed literals.
`timescale 1ns/1ps
module tb_aes_ct_serializer;
  import aes_pkg::*;

  localparam int N     = AES_WORDS_PER_BLK;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset, blk_valid, word_ready;
  aes_block_t blk_data;
  logic       word_valid, word_last, full, overflow;
  aes_word_t  word_data;
`ifdef AES_CT_PARITY_EN
  logic       word_par;
`endif

  int checks = 0;
  int fails  = 0;
  bit checkEn = 1'b0;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } word_t;

  word_t mq[$];
  bit    mOvf;
  int    mBlocks;
  bit    mXfer, mPopBlk, mAccept;
  word_t mWord;
  logic        expV, expL, expF;
  logic [31:0] expD;

  always #5 clk = ~clk;

  aes_ct_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .full       (full),
    .overflow   (overflow)
`ifdef AES_CT_PARITY_EN
    ,
    .word_par   (word_par)
`endif
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of words; a block occupies a slot until its last word leaves.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mOvf = 1'b0;
    end else begin
      mBlocks = (mq.size() + N - 1) / N;
      mXfer   = (mq.size() != 0) && word_ready;
      mPopBlk = mXfer && mq[0].last;
      mAccept = blk_valid && ((mBlocks < DEPTH) || mPopBlk);
      if (mXfer) void'(mq.pop_front());
      if (mAccept) begin
        for (int i = 0; i < N; i++) begin
          mWord.d    = blk_data[AES_DATA_W-1-i*AES_WORD_W -: AES_WORD_W];
          mWord.last = (i == N - 1);
          mq.push_back(mWord);
        end
      end else if (blk_valid) begin
        mOvf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      expV = (mq.size() != 0);
      expD = expV ? mq[0].d : 32'h0;
      expL = expV && mq[0].last;
      expF = (((mq.size() + N - 1) / N) == DEPTH);
      compare("model.word_valid", {31'b0, word_valid}, {31'b0, expV});
      compare("model.word_data", word_data, expD);
      compare("model.word_last", {31'b0, word_last}, {31'b0, expL});
      compare("model.full", {31'b0, full}, {31'b0, expF});
      compare("model.overflow", {31'b0, overflow}, {31'b0, mOvf});
`ifdef AES_CT_PARITY_EN
      compare("model.word_par", {31'b0, word_par}, {31'b0, ^expD});
`endif
    end
  end

  task automatic applyStimulus(input logic bv, input aes_block_t bd, input logic rdy, input logic rst);
    blk_valid  = bv;
    blk_data   = bd;
    word_ready = rdy;
    reset      = rst;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [31:0] d,
                             input logic l, input logic f, input logic o);
    compare({tag, ".valid"}, {31'b0, word_valid}, {31'b0, v});
    compare({tag, ".data"}, word_data, d);
    compare({tag, ".last"}, {31'b0, word_last}, {31'b0, l});
    compare({tag, ".full"}, {31'b0, full}, {31'b0, f});
    compare({tag, ".overflow"}, {31'b0, overflow}, {31'b0, o});
  endtask

  task automatic pushBlock(input aes_block_t b, input logic rdy);
    applyStimulus(1'b1, b, rdy, 1'b0);
    step();
    applyStimulus(1'b0, b, rdy, 1'b0);
  endtask

  localparam aes_block_t K1 = 128'h3925841D_02DC09FB_DC118597_196A0B32;
  localparam aes_block_t BA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam aes_block_t BB = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam aes_block_t BC = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
  localparam aes_block_t BG = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam aes_block_t BH = 128'hA5A5A5A5_5A5A5A5A_0BADCAFE_FEEDFACE;
  localparam aes_block_t BE = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam aes_block_t BF = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam aes_block_t BD = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;

  logic [31:0] wordsAB [8] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                               32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
  logic [31:0] wordsFD [8] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                               32'hD0D1D2D3, 32'hD4D5D6D7, 32'hD8D9DADB, 32'hDCDDDEDF};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    step();
    step();
    checkEn = 1'b1;
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step();

    $display("[TB] single block, ready tied high");
    pushBlock(K1, 1'b1);
    checkOutput("t1.w0", 1'b1, 32'h3925841D, 1'b0, 1'b0, 1'b0);
    step(); checkOutput("t1.w1", 1'b1, 32'h02DC09FB, 1'b0, 1'b0, 1'b0);
    step(); checkOutput("t1.w2", 1'b1, 32'hDC118597, 1'b0, 1'b0, 1'b0);
    step(); checkOutput("t1.w3", 1'b1, 32'h196A0B32, 1'b1, 1'b0, 1'b0);
    step(); checkOutput("t1.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] backpressure at widx=1");
    pushBlock(K1, 1'b1);
    checkOutput("t2.w0", 1'b1, 32'h3925841D, 1'b0, 1'b0, 1'b0);
    step(); checkOutput("t2.w1", 1'b1, 32'h02DC09FB, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, K1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); checkOutput("t2.hold", 1'b1, 32'h02DC09FB, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, K1, 1'b1, 1'b0);
    step(); checkOutput("t2.w2", 1'b1, 32'hDC118597, 1'b0, 1'b0, 1'b0);
    step(); checkOutput("t2.w3", 1'b1, 32'h196A0B32, 1'b1, 1'b0, 1'b0);
    step(); checkOutput("t2.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] fill and overflow");
    applyStimulus(1'b1, BA, 1'b0, 1'b0);
    step(); checkOutput("t3.a", 1'b1, 32'h00112233, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, BB, 1'b0, 1'b0);
    step(); checkOutput("t3.b", 1'b1, 32'h00112233, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, BC, 1'b0, 1'b0);
    step(); checkOutput("t3.c", 1'b1, 32'h00112233, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, BC, 1'b0, 1'b0);
    step(); checkOutput("t3.sticky", 1'b1, 32'h00112233, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, BC, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t3.drain", 1'b1, wordsAB[i], (i % 4) == 3, i < 4, 1'b1);
      step();
    end
    checkOutput("t3.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-block");
    pushBlock(BG, 1'b1);
    checkOutput("t4.w0", 1'b1, 32'h0F1E2D3C, 1'b0, 1'b0, 1'b1);
    step(); checkOutput("t4.w1", 1'b1, 32'h4B5A6978, 1'b0, 1'b0, 1'b1);
    step(); checkOutput("t4.w2", 1'b1, 32'h8796A5B4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, BG, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, BG, 1'b1, 1'b0);
    checkOutput("t4.after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    pushBlock(BH, 1'b1);
    checkOutput("t4.new0", 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    step(); checkOutput("t4.new1", 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    checkOutput("t4.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] push and pop in the same cycle while full");
    applyStimulus(1'b1, BE, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, BF, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, BF, 1'b0, 1'b0);
    checkOutput("t5.full", 1'b1, 32'h01020304, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, BF, 1'b1, 1'b0);
    step(); checkOutput("t5.e1", 1'b1, 32'h05060708, 1'b0, 1'b1, 1'b0);
    step(); checkOutput("t5.e2", 1'b1, 32'h090A0B0C, 1'b0, 1'b1, 1'b0);
    step(); checkOutput("t5.e3", 1'b1, 32'h0D0E0F10, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, BD, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, BD, 1'b1, 1'b0);
    checkOutput("t5.f0", 1'b1, wordsFD[0], 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(); checkOutput("t5.drain", 1'b1, wordsFD[i], (i % 4) == 3, i < 4, 1'b0);
    end
    step(); checkOutput("t5.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef AES_CT_PARITY_EN
    $display("[TB] word parity");
    pushBlock(128'h00000001_00000003_00000000_FFFFFFFF, 1'b1);
    compare("t6.par0", {31'b0, word_par}, 32'h1);
    step(); compare("t6.par1", {31'b0, word_par}, 32'h0);
    step(); step(); step();
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
